// File: rtl/collision_matrix_analyzer_if.sv
// rtl/collision_matrix_analyzer_if.sv - Avalon-MM word bus between the Nios host and the collision matrix
interface collision_matrix_analyzer_if;
    logic [7:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );
endinterface

// File: rtl/collision_matrix_analyzer.sv
// rtl/collision_matrix_analyzer.sv - per-pixel sprite level-collision matrix, double-buffered per frame
// Optional macro COLLISION_IRQ_EN adds irq_en, the sticky irq and STATUS bits 1-2.
module collision_matrix_analyzer #(
    parameter int NUM_LAYERS = 4,
    parameter int LEVEL_W    = 5,
    parameter int ID_W       = 9,
    parameter int ENTRY_W    = 23,
    parameter int BASE_ADDR  = 37
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          new_pixel,
    input  logic                          new_frame,
    input  logic [NUM_LAYERS*ENTRY_W-1:0] h_in,
    collision_matrix_analyzer_if.slave    bus,
    output logic                          collision,
    output logic                          irq
);
    localparam int NUM_LEVELS = 1 << LEVEL_W;
    localparam logic [31:0] ROW_LO   = 32'(BASE_ADDR);
    localparam logic [31:0] STATUS_A = 32'(BASE_ADDR + NUM_LEVELS);

    logic [LEVEL_W-1:0] lvls [NUM_LAYERS];
    logic [ID_W-1:0]    ids  [NUM_LAYERS];

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_entry
        assign lvls[k] = h_in[k*ENTRY_W + ENTRY_W - 1 -: LEVEL_W];
        assign ids[k]  = h_in[k*ENTRY_W + ENTRY_W - LEVEL_W - 1 -: ID_W];
    end

    logic [NUM_LEVELS-1:0][NUM_LEVELS-1:0] pair_next;
    logic [NUM_LEVELS-1:0][NUM_LEVELS-1:0] pair_mask;
    logic [NUM_LEVELS-1:0][NUM_LEVELS-1:0] active;
    logic [NUM_LEVELS-1:0][NUM_LEVELS-1:0] shadow;
    logic                                  nf_d;
    logic [7:0]                            frame_cnt;
    logic                                  irq_en;

    always_comb begin
        pair_next = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = 0; j < NUM_LAYERS; j++) begin
                if (i != j && ids[i] != '0 && ids[j] != '0 && lvls[i] != lvls[j])
                    pair_next[lvls[i]][lvls[j]] = 1'b1;
            end
        end
    end

    logic [31:0]        addr32;
    logic [31:0]        row_off;
    logic [LEVEL_W-1:0] row_sel;
    logic               in_rows;
    logic               is_status;
    logic [31:0]        status_word;

    assign addr32    = {24'd0, bus.address};
    assign row_off   = addr32 - ROW_LO;
    assign row_sel   = row_off[LEVEL_W-1:0];
    assign in_rows   = (addr32 >= ROW_LO) && (addr32 < STATUS_A);
    assign is_status = (addr32 == STATUS_A);

    always_comb begin
        status_word       = '0;
        status_word[0]    = collision;
        status_word[15:8] = frame_cnt;
`ifdef COLLISION_IRQ_EN
        status_word[1]    = irq;
        status_word[2]    = irq_en;
`endif
    end

    // In the aligned boundary cycle pair_mask holds the pixel that arrived with
    // new_frame; it seeds the new frame instead of landing in the old one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_mask <= '0;
            nf_d      <= 1'b0;
            active    <= '0;
            shadow    <= '0;
            frame_cnt <= '0;
            collision <= 1'b0;
        end else begin
            pair_mask <= new_pixel ? pair_next : '0;
            nf_d      <= new_frame;
            if (nf_d) begin
                shadow    <= active;
                active    <= pair_mask;
                frame_cnt <= frame_cnt + 8'd1;
                collision <= |active;
            end else begin
                active <= active | pair_mask;
            end
        end
    end

    // Registered read: a read coincident with a swap sees the old shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                if (in_rows)
                    bus.readdata <= 32'(shadow[row_sel]);
                else if (is_status)
                    bus.readdata <= status_word;
                else
                    bus.readdata <= '0;
            end
        end
    end

`ifdef COLLISION_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (bus.write && is_status)
                irq_en <= bus.writedata[2];
            if (nf_d && irq_en && (|active))
                irq <= 1'b1;
            else if (bus.write && is_status && bus.writedata[1])
                irq <= 1'b0;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{h_in, row_off, bus.writedata, bus.write, irq_en};
endmodule
